// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd dispatcher and its operand FIFO.
package gcd_pkg;

    localparam int GCD_NBITS = 32;

    typedef enum logic [1:0] {
        DSP_IDLE  = 2'd0,
        DSP_ISSUE = 2'd1,
        DSP_WAIT  = 2'd2
    } dsp_state_t;

endpackage

// File: rtl/gcd_opnd_fifo.sv
// Synchronous operand-pair FIFO. Pointers wrap naturally at DEPTH (power of 2);
// occupancy is kept in a separate counter so full and empty are unambiguous.
// Pushes while full and pops while empty are ignored.
module gcd_opnd_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Feeds buffered operand pairs to an external gcd engine one job at a time and
// returns {result, operands, cycle count} in FIFO order through a one-entry slot.
// Handshakes: a transfer happens on any rising edge where valid && ready; valid
// holds its payload until that edge. A new job is only issued when the result
// slot is free (or freeing this cycle), so done never lands on a full slot.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int NBITS = GCD_NBITS,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NBITS-1:0]           in_a,
    input  logic [NBITS-1:0]           in_b,
    output logic [NBITS-1:0]           gcd_a,
    output logic [NBITS-1:0]           gcd_b,
    output logic                       gcd_start,
    input  logic                       gcd_done,
    input  logic [NBITS-1:0]           gcd_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NBITS-1:0]           out_result,
    output logic [NBITS-1:0]           out_a,
    output logic [NBITS-1:0]           out_b,
    output logic [CW-1:0]              out_cycles,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);

    dsp_state_t         state_q, state_d;
    logic [NBITS-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic               ov_q, ov_d;
    logic [NBITS-1:0]   res_q, res_d, oa_q, oa_d, ob_q, ob_d;
    logic [CW-1:0]      oc_q, oc_d;
    logic               err_q, err_d;
    logic               fifo_full, fifo_empty, fifo_pop, slot_free;
    logic [2*NBITS-1:0] fifo_rdata;

    gcd_opnd_fifo #(.W(2*NBITS), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .wdata_i ({in_a, in_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign in_ready   = !fifo_full;
    assign slot_free  = !ov_q || out_ready;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    assign gcd_start  = (state_q == DSP_ISSUE);
    assign gcd_a      = a_q;
    assign gcd_b      = b_q;
    assign out_valid  = ov_q;
    assign out_result = res_q;
    assign out_a      = oa_q;
    assign out_b      = ob_q;
    assign out_cycles = oc_q;
    assign err        = err_q;

    // Job sequencing, cycle counting, result capture and error flagging.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        ov_d     = ov_q && !out_ready;
        res_d    = res_q;
        oa_d     = oa_q;
        ob_d     = ob_q;
        oc_d     = oc_q;
        err_d    = err_q || (gcd_done && (state_q != DSP_WAIT));
        fifo_pop = 1'b0;
        case (state_q)
            DSP_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop = 1'b1;
                    a_d      = fifo_rdata[2*NBITS-1:NBITS];
                    b_d      = fifo_rdata[NBITS-1:0];
                    cnt_d    = '0;
                    state_d  = DSP_ISSUE;
                end
            end
            DSP_ISSUE: begin
                cnt_d   = CW'(1);
                state_d = DSP_WAIT;
            end
            DSP_WAIT: begin
                cnt_d = cnt_inc;
                if (gcd_done) begin
                    res_d   = gcd_result;
                    oa_d    = a_q;
                    ob_d    = b_q;
                    oc_d    = cnt_inc;
                    ov_d    = 1'b1;
                    state_d = DSP_IDLE;
                end
            end
            default: state_d = DSP_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DSP_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            oc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            oc_q    <= oc_d;
            err_q   <= err_d;
        end
    end

endmodule
